// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around the 32-point pipelined FFT core: load, stream, capture, read.
// Define FFT_FRAME_CTRL_MAG_EN to add the registered rd_mag (|re|+|im|) read output.
module fft_frame_ctrl #(
    parameter int N_PTS   = 32,
    parameter int IN_W    = 12,
    parameter int OUT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [IN_W-1:0]          s_re,
    input  logic [IN_W-1:0]          s_im,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    input  logic                     rd_en,
    input  logic [$clog2(N_PTS)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [OUT_W-1:0]         rd_re,
    output logic [OUT_W-1:0]         rd_im,
`ifdef FFT_FRAME_CTRL_MAG_EN
    output logic [OUT_W:0]           rd_mag,
`endif
    output logic                     fft_reset,
    output logic                     fft_in_valid,
    output logic [IN_W-1:0]          fft_din_r,
    output logic [IN_W-1:0]          fft_din_i,
    input  logic                     fft_out_valid,
    input  logic [OUT_W-1:0]         fft_dout_r,
    input  logic [OUT_W-1:0]         fft_dout_i
);

    localparam int IDX_W = $clog2(N_PTS);
    localparam int CNT_W = IDX_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FLUSH, S_LOAD, S_STREAM, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] cap_idx;
    logic [TO_W-1:0]  wcnt;

    logic [IN_W-1:0]  buf_re [N_PTS];
    logic [IN_W-1:0]  buf_im [N_PTS];
    logic [OUT_W-1:0] res_re [N_PTS];
    logic [OUT_W-1:0] res_im [N_PTS];

    assign nxt_ptr = ptr + 1'b1;
    // The WAIT cycle that sees out_valid supplies bin 0; CAPTURE supplies the rest.
    assign cap_idx = (state == S_CAPTURE) ? ptr : '0;

`ifdef FFT_FRAME_CTRL_MAG_EN
    function automatic logic [OUT_W:0] abs_ext(input logic [OUT_W-1:0] v);
        logic [OUT_W:0] e;
        e = {v[OUT_W-1], v};
        return v[OUT_W-1] ? (~e + 1'b1) : e;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_LOAD && s_valid && s_ready && !clear) begin
                buf_re[cnt[IDX_W-1:0]] <= s_re;
                buf_im[cnt[IDX_W-1:0]] <= s_im;
            end
            if ((state == S_WAIT && fft_out_valid) || state == S_CAPTURE) begin
                res_re[cap_idx] <= fft_dout_r;
                res_im[cap_idx] <= fft_dout_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FLUSH;
            cnt          <= '0;
            ptr          <= '0;
            wcnt         <= '0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            rd_valid     <= 1'b0;
            rd_re        <= '0;
            rd_im        <= '0;
`ifdef FFT_FRAME_CTRL_MAG_EN
            rd_mag       <= '0;
`endif
            fft_reset    <= 1'b1;
            fft_in_valid <= 1'b0;
            fft_din_r    <= '0;
            fft_din_i    <= '0;
        end else begin
            rd_valid <= 1'b0;
            unique case (state)
                S_FLUSH: begin
                    state     <= S_LOAD;
                    cnt       <= '0;
                    ptr       <= '0;
                    wcnt      <= '0;
                    fft_reset <= 1'b0;
                    s_ready   <= 1'b1;
                end
                S_LOAD: begin
                    if (clear) begin
                        state     <= S_FLUSH;
                        cnt       <= '0;
                        error     <= 1'b0;
                        s_ready   <= 1'b0;
                        fft_reset <= 1'b1;
                    end else if (start && cnt == CNT_W'(N_PTS)) begin
                        state        <= S_STREAM;
                        ptr          <= '0;
                        busy         <= 1'b1;
                        fft_in_valid <= 1'b1;
                        fft_din_r    <= buf_re[0];
                        fft_din_i    <= buf_im[0];
                    end else if (s_valid && s_ready) begin
                        cnt     <= cnt + 1'b1;
                        s_ready <= (cnt != CNT_W'(N_PTS - 1));
                    end
                end
                S_STREAM: begin
                    if (ptr == IDX_W'(N_PTS - 1)) begin
                        state        <= S_WAIT;
                        wcnt         <= '0;
                        fft_in_valid <= 1'b0;
                        fft_din_r    <= '0;
                        fft_din_i    <= '0;
                    end else begin
                        ptr       <= nxt_ptr;
                        fft_din_r <= buf_re[nxt_ptr];
                        fft_din_i <= buf_im[nxt_ptr];
                    end
                end
                S_WAIT: begin
                    if (fft_out_valid) begin
                        state <= S_CAPTURE;
                        ptr   <= IDX_W'(1);
                    end else if (wcnt == TO_W'(TIMEOUT - 1)) begin
                        state     <= S_FLUSH;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        fft_reset <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (ptr == IDX_W'(N_PTS - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ptr <= nxt_ptr;
                    end
                end
                S_DONE: begin
                    if (rd_en) begin
                        rd_valid <= 1'b1;
                        rd_re    <= res_re[rd_idx];
                        rd_im    <= res_im[rd_idx];
`ifdef FFT_FRAME_CTRL_MAG_EN
                        rd_mag   <= abs_ext(res_re[rd_idx]) + abs_ext(res_im[rd_idx]);
`endif
                    end
                    if (clear) begin
                        state     <= S_FLUSH;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        fft_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_FLUSH;
                    fft_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: directed frames with random data, stub FFT, read-back model.
// Honours FFT_FRAME_CTRL_MAG_EN to also check rd_mag.
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic        fft_out_valid = 1'b0;
    logic [11:0] s_re = '0;
    logic [11:0] s_im = '0;
    logic [4:0]  rd_idx = '0;
    logic [15:0] fft_dout_r = '0;
    logic [15:0] fft_dout_i = '0;

    logic        s_ready, busy, done, error, rd_valid;
    logic        fft_reset, fft_in_valid;
    logic [15:0] rd_re, rd_im;
    logic [11:0] fft_din_r, fft_din_i;
`ifdef FFT_FRAME_CTRL_MAG_EN
    logic [16:0] rd_mag;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int re;
        int im;
    } cplx_t;

    cplx_t q[$];
    int    res_re[32];
    int    res_im[32];

    fft_frame_ctrl dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .start(start), .clear(clear),
        .busy(busy), .done(done), .error(error),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_re(rd_re), .rd_im(rd_im),
`ifdef FFT_FRAME_CTRL_MAG_EN
        .rd_mag(rd_mag),
`endif
        .fft_reset(fft_reset), .fft_in_valid(fft_in_valid),
        .fft_din_r(fft_din_r), .fft_din_i(fft_din_i),
        .fft_out_valid(fft_out_valid),
        .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push(input int re, input int im);
        int g = 0;
        s_valid = 1'b1;
        s_re = 12'(re);
        s_im = 12'(im);
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready_wait", (g < 50), 1);
        if (s_ready) q.push_back('{re, im});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(rnd12(), rnd12());
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_stream(input int reset_at);
        chk("stream_model_len", q.size(), 32);
        for (int k = 0; k < 32; k++) begin
            chk("stream_in_valid", fft_in_valid, 1);
            chk("stream_busy", busy, 1);
            chk("stream_din_r", $signed(fft_din_r), q[k].re);
            chk("stream_din_i", $signed(fft_din_i), q[k].im);
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_in_valid", fft_in_valid, 0);
                chk("rst_fft_reset", fft_reset, 1);
                chk("rst_busy", busy, 0);
                reset = 1'b0;
                @(negedge clk);
                chk("rst_flush_over", fft_reset, 0);
                chk("rst_load_ready", s_ready, 1);
                q.delete();
                return;
            end
            @(negedge clk);
        end
        chk("stream_end_valid", fft_in_valid, 0);
        chk("wait_busy", busy, 1);
        q.delete();
    endtask

    task automatic feed_results(input int delay, input bit rand_valid);
        repeat (delay) @(negedge clk);
        chk("wait_done_low", done, 0);
        for (int j = 0; j < 32; j++) begin
            fft_out_valid = (j == 0) ? 1'b1 :
                            (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            fft_dout_r = 16'(res_re[j]);
            fft_dout_i = 16'(res_im[j]);
            if (j == 31) chk("capture_done_low", done, 0);
            @(negedge clk);
        end
        fft_out_valid = 1'b0;
        chk("done_high", done, 1);
        chk("done_busy", busy, 0);
        chk("done_s_ready", s_ready, 0);
    endtask

    task automatic read_bin(input int idx);
        rd_en = 1'b1;
        rd_idx = 5'(idx);
        @(negedge clk);
        chk("rd_valid", rd_valid, 1);
        chk("rd_re", $signed(rd_re), res_re[idx]);
        chk("rd_im", $signed(rd_im), res_im[idx]);
`ifdef FFT_FRAME_CTRL_MAG_EN
        chk("rd_mag", rd_mag, iabs(res_re[idx]) + iabs(res_im[idx]));
`endif
    endtask

    task automatic read_some(input int n);
        int last = 0;
        for (int i = 0; i < n; i++) begin
            last = (i == 0) ? 0 : (i == 1) ? 31 : int'($urandom_range(0, 31));
            read_bin(last);
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd_idle_valid", rd_valid, 0);
        chk("rd_idle_hold", $signed(rd_re), res_re[last]);
    endtask

    task automatic rand_results();
        for (int j = 0; j < 32; j++) begin
            res_re[j] = rnd16();
            res_im[j] = rnd16();
        end
    endtask

    task automatic clear_done();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_fft_reset", fft_reset, 1);
        chk("clr_done", done, 0);
        chk("clr_error", error, 0);
        @(negedge clk);
        chk("clr_fft_reset_pulse", fft_reset, 0);
        chk("clr_s_ready", s_ready, 1);
        rd_en = 1'b1;
        rd_idx = 5'd3;
        @(negedge clk);
        chk("clr_rd_valid", rd_valid, 0);
        rd_en = 1'b0;
    endtask

    initial begin
        int n;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_fft_reset", fft_reset, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_re", rd_re, 0);
        chk("rst_in_valid", fft_in_valid, 0);
        chk("rst_din_r", fft_din_r, 0);
        reset = 1'b0;
        chk("flush_fft_reset", fft_reset, 1);
        @(negedge clk);
        chk("load_fft_reset", fft_reset, 0);
        chk("load_s_ready", s_ready, 1);

        // start ignored while partially loaded
        for (int k = 0; k < 20; k++) push(k, -k);
        do_start();
        chk("early_start_valid", fft_in_valid, 0);
        chk("early_start_ready", s_ready, 1);
        chk("early_start_busy", busy, 0);
        for (int k = 20; k < 32; k++) push(k, -k);
        chk("full_s_ready", s_ready, 0);
        do_start();
        check_stream(-1);
        for (int j = 0; j < 32; j++) begin
            res_re[j] = 100 + j;
            res_im[j] = -j;
        end
        feed_results(10, 1'b0);
        read_bin(7);
        read_some(6);
        clear_done();

        // timeout
        load_rand(32);
        do_start();
        check_stream(-1);
        n = 0;
        while (!error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 255);
        chk("to_fft_reset", fft_reset, 1);
        chk("to_done", done, 0);
        chk("to_busy", busy, 0);
        @(negedge clk);
        chk("to_fft_reset_pulse", fft_reset, 0);
        chk("to_s_ready", s_ready, 1);
        chk("to_error_sticky", error, 1);
        chk("to_done_low", done, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("load_clear_error", error, 0);
        chk("load_clear_flush", fft_reset, 1);
        @(negedge clk);
        chk("load_clear_ready", s_ready, 1);

        // sample and start together at count 31
        load_rand(31);
        start = 1'b1;
        push(rnd12(), rnd12());
        start = 1'b0;
        chk("c31_in_valid", fft_in_valid, 0);
        chk("c31_s_ready", s_ready, 0);
        chk("c31_busy", busy, 0);
        do_start();
        check_stream(-1);
        rand_results();
        res_re[5] = -32768;
        res_im[5] = -32768;
        res_re[6] = 32767;
        res_im[6] = -32768;
        feed_results(int'($urandom_range(0, 40)), 1'b1);
        read_bin(5);
        read_bin(6);
        read_some(34);
        clear_done();

        // start and clear together in LOAD
        load_rand(32);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("sc_in_valid", fft_in_valid, 0);
        chk("sc_fft_reset", fft_reset, 1);
        @(negedge clk);
        chk("sc_s_ready", s_ready, 1);
        q.delete();
        load_rand(32);
        do_start();
        check_stream(-1);
        rand_results();
        feed_results(int'($urandom_range(1, 60)), 1'b1);
        read_some(10);
        clear_done();

        // reset during stream cycle 15
        load_rand(32);
        do_start();
        check_stream(15);
        load_rand(31);
        chk("post_rst_ready31", s_ready, 1);
        load_rand(1);
        chk("post_rst_ready32", s_ready, 0);
        do_start();
        check_stream(-1);
        rand_results();
        feed_results(int'($urandom_range(0, 20)), 1'b1);
        read_some(8);
        clear_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the 32-point pipelined FFT core used as the RS5 accelerator.
- Buffers 32 complex input samples from a requester (valid/ready), then streams them into the FFT on 32 consecutive cycles.
- Captures the 32 natural-order results into a result buffer, exposes them by index, and pulses the core reset between frames (the core's result latch never self-clears).
- Sits between the processor-side register interface and the FFT instance.

Parameters:
- N_PTS, 32, frame length; fixed, index width log2(N_PTS)=5.
- IN_W, 12, input sample component width (signed).
- OUT_W, 16, FFT result component width (signed).
- TIMEOUT, 255, maximum WAIT cycles before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  sample offered
- s_ready  out  1  sample accepted when s_valid&&s_ready
- s_re  in  IN_W  sample real (signed)
- s_im  in  IN_W  sample imaginary (signed)
- start  in  1  begin transform (honoured only when buffer full)
- clear  in  1  release results, return to load
- busy  out  1  STREAM/WAIT/CAPTURE active
- done  out  1  results valid (level)
- error  out  1  sticky timeout flag, cleared by clear or reset
- rd_en  in  1  result read request
- rd_idx  in  5  result bin index
- rd_valid  out  1  read data valid
- rd_re  out  OUT_W  result real
- rd_im  out  OUT_W  result imaginary
- fft_reset  out  1  reset to FFT core
- fft_in_valid  out  1  FFT in_valid
- fft_din_r  out  IN_W  FFT din_r
- fft_din_i  out  IN_W  FFT din_i
- fft_out_valid  in  1  FFT out_valid
- fft_dout_r  in  OUT_W  FFT dout_r
- fft_dout_i  in  OUT_W  FFT dout_i

Behaviour:
- Reset: state=FLUSH, sample count=0, s_ready=0, busy=0, done=0, error=0, rd_valid=0, rd_re/rd_im=0, fft_in_valid=0, fft_din_*=0, fft_reset=1. Buffer contents are don't-care.
- All outputs are registered.
- FLUSH (1 cycle): fft_reset=1, clear sample and capture counters -> LOAD.
- LOAD:
  - s_ready=1 while count<32.
  - Each handshake writes buffer[count] and increments count.
  - At count=32, s_ready=0.
  - start with count=32 -> STREAM next cycle.
  - start with count<32 is ignored (no error).
- STREAM (exactly 32 cycles): fft_in_valid=1 continuously. fft_din_r/i = buffer[k], k=0..31 in order. busy=1. After k=31 -> WAIT with fft_in_valid=0.
- WAIT:
  - Cycle counter runs.
  - First cycle fft_out_valid=1 -> CAPTURE, and that cycle's fft_dout is stored as result[0].
  - If the counter reaches TIMEOUT without fft_out_valid -> error=1 -> FLUSH (results discarded, done stays 0).
- CAPTURE: on 32 consecutive cycles (including the entry cycle), store fft_dout_r/i into result[j], j=0..31. fft_out_valid is not rechecked. After j=31 -> DONE.
- DONE:
  - done=1, busy=0, s_ready=0.
  - rd_en in DONE -> next cycle rd_valid=1, rd_re/rd_im=result[rd_idx].
  - rd_en outside DONE -> rd_valid=0, data held.
  - Back-to-back reads give one result per cycle.
  - clear -> FLUSH, done=0 next cycle.
- clear in LOAD -> FLUSH (buffer discarded, count=0). clear in STREAM/WAIT/CAPTURE is ignored.
- Simultaneous start and clear in LOAD: clear wins.
- Simultaneous s_valid and start at count=31: the sample is accepted, start is ignored (count was <32 when sampled).
- reset mid-frame: immediate return to reset values, FLUSH on the first cycle after reset deasserts.
- Result storage is a 32-entry register array, written only in CAPTURE.

Optional Feature:
- Macro FFT_FRAME_CTRL_MAG_EN.
- Defined: adds output rd_mag [OUT_W:0], registered alongside rd_re/rd_im. rd_mag = |result.re| + |result.im|, unsigned, computed at OUT_W+1 bits with no saturation. |-32768| = 32768.
- Undefined: port and logic absent, all other behaviour identical.

Test Plan:
- Load 32 samples (re=k, im=-k), then start -> fft_in_valid high exactly 32 consecutive cycles; fft_din_r = 0,1,...,31 and fft_din_i = 0,-1,...,-31 in order; busy=1 throughout.
- Stub FFT asserts fft_out_valid 10 cycles after the stream, with dout_r=100+j, dout_i=-j -> done=1. rd_idx=7 returns rd_re=107, rd_im=-7 with rd_valid one cycle after rd_en. MAG_EN: rd_mag=114.
- Stub never asserts fft_out_valid -> error=1 after 255 WAIT cycles; fft_reset pulses 1 cycle; state returns to LOAD with s_ready=1; done stays 0.
- start after only 20 samples -> no fft_in_valid, s_ready stays 1. Load 12 more, then start -> stream begins.
- In DONE, assert clear -> fft_reset=1 for exactly 1 cycle, done=0, s_ready=1. rd_en afterwards gives rd_valid=0.
- Assert reset during STREAM cycle 15 -> fft_in_valid=0 and fft_reset=1 the following cycle; after deassert, one FLUSH cycle, then LOAD with count=0.
